// File: rtl/diffio_checker_clken_generator.sv
// Multi-channel clock-enable generator: shared prescaler plus per-channel programmable dividers
// with continuous/one-shot modes, shadowed divisor updates, toggle outputs and global SYNC realign.
module diffio_checker_clken_generator #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PRESCALE  = 400,
  parameter int RESET_DIV = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 GLOBAL_EN,
  input  logic                 SYNC,
  input  logic [NUM_CH-1:0]    CH_EN,
  input  logic [NUM_CH-1:0]    MODE,
  input  logic [NUM_CH-1:0]    START,
  input  logic [NUM_CH-1:0]    DIV_WE,
  input  logic [CNT_WIDTH-1:0] DIV_DATA,
  output logic                 BASE_TICK,
  output logic [NUM_CH-1:0]    CLK_EN,
  output logic [NUM_CH-1:0]    CLK_DIV,
  output logic [NUM_CH-1:0]    BUSY
);

  localparam int                   PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(RESET_DIV);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_tick;

  // SYNC masks the tick so no channel can terminate on the realign cycle.
  assign w_tick    = (r_pre_cnt == PRE_LAST) && GLOBAL_EN && !SYNC;
  assign BASE_TICK = w_tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre_cnt <= '0;
    end else if (SYNC) begin
      r_pre_cnt <= '0;
    end else if (GLOBAL_EN) begin
      r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + PRE_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t               r_state, w_state_next;
      logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
      logic [CNT_WIDTH-1:0] r_div, w_div_next;
      logic [CNT_WIDTH-1:0] r_shadow, w_shadow_next;
      logic                 r_clk_en, w_clk_en_next;
      logic                 r_clk_div, w_clk_div_next;
      logic                 w_term;

      always_comb begin
        w_shadow_next  = DIV_WE[gi] ? DIV_DATA : r_shadow;
        w_term         = (r_div != '0) && (r_cnt == r_div - CNT_WIDTH'(1));
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_div_next     = r_div;
        w_clk_en_next  = 1'b0;
        w_clk_div_next = r_clk_div;
        if (SYNC) begin
          w_cnt_next     = '0;
          w_clk_div_next = 1'b0;
          w_div_next     = w_shadow_next;
        end else begin
          case (r_state)
            S_IDLE: begin
              // Idle channels track the shadow so a write takes effect at once.
              w_div_next = w_shadow_next;
              if (CH_EN[gi] && (!MODE[gi] || START[gi])) begin
                w_state_next = S_RUN;
              end
            end
            S_RUN: begin
              if (!CH_EN[gi]) begin
                w_state_next   = S_IDLE;
                w_cnt_next     = '0;
                w_clk_div_next = 1'b0;
              end else if (w_tick) begin
                if (w_term) begin
                  // Period boundary: the only point where a running divisor may change.
                  w_cnt_next     = '0;
                  w_clk_en_next  = 1'b1;
                  w_clk_div_next = ~r_clk_div;
                  w_div_next     = w_shadow_next;
                  if (MODE[gi]) begin
                    w_state_next = S_IDLE;
                  end
                end else if (r_div != '0) begin
                  w_cnt_next = r_cnt + CNT_WIDTH'(1);
                end
              end
            end
            default: w_state_next = S_IDLE;
          endcase
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_div     <= DIV_RST;
          r_shadow  <= DIV_RST;
          r_clk_en  <= 1'b0;
          r_clk_div <= 1'b0;
        end else begin
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_div     <= w_div_next;
          r_shadow  <= w_shadow_next;
          r_clk_en  <= w_clk_en_next;
          r_clk_div <= w_clk_div_next;
        end
      end

      assign CLK_EN[gi]  = r_clk_en;
      assign CLK_DIV[gi] = r_clk_div;
      assign BUSY[gi]    = (r_state == S_RUN);
    end
  endgenerate

endmodule

// File: doc/diffio_checker_clken_generator.md
Name: diffio_checker_clken_generator

Overview:
- Multi-channel clock-enable generator for the differential IO checker.
- A shared prescaler divides CLK down to a base tick. Each of NUM_CH channels divides the base tick by its own runtime-programmable divisor.
- Each channel supports continuous or one-shot mode, shadowed glitch-free divisor updates, a 50% toggle output and a global SYNC realignment.
- Feeds per-lane pattern generators and checkers that need independent, phase-aligned strobes.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- CNT_WIDTH, 16, width of divisor and channel counters
- PRESCALE, 400, CLK cycles per base tick (>=1; 400 = 50 MHz to 125 kHz)
- RESET_DIV, 1, reset value of every channel's active and shadow divisor

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- GLOBAL_EN  in  1  prescaler run enable; low freezes the prescaler
- SYNC  in  1  one-cycle realign pulse for prescaler and all channels
- CH_EN  in  NUM_CH  per-channel enable
- MODE  in  NUM_CH  per channel: 0 continuous, 1 one-shot
- START  in  NUM_CH  one-shot trigger pulse
- DIV_WE  in  NUM_CH  per-channel divisor write strobe
- DIV_DATA  in  CNT_WIDTH  divisor value shared by all write strobes
- BASE_TICK  out  1  prescaler terminal pulse
- CLK_EN  out  NUM_CH  one-cycle enable pulse per channel period
- CLK_DIV  out  NUM_CH  toggle output, period 2*D base ticks
- BUSY  out  NUM_CH  channel in RUN state

Behaviour:
- One clock, CLK. Reset RST is synchronous and active-high.
- Priority: RST > SYNC > normal operation.
- Reset values:
  - prescaler count 0
  - every channel in IDLE with count 0
  - active and shadow divisors = RESET_DIV
  - CLK_EN, CLK_DIV and BUSY all 0
- Prescaler:
  - pre_cnt is $clog2(PRESCALE) bits wide, minimum 1 bit.
  - When GLOBAL_EN=1 it counts 0..PRESCALE-1 and wraps to 0.
  - When GLOBAL_EN=0 it holds its value.
  - BASE_TICK = (pre_cnt==PRESCALE-1) & GLOBAL_EN, decoded from the registered count.
  - PRESCALE=1 gives BASE_TICK every cycle while GLOBAL_EN=1.
- Channel state machine, states IDLE and RUN:
  - IDLE -> RUN when CH_EN=1 and either MODE=0, or MODE=1 with START=1.
  - RUN -> IDLE when CH_EN=0 (count cleared, CLK_DIV driven 0, no pulse).
  - RUN -> IDLE in one-shot mode after its single terminal pulse.
  - START is ignored while in RUN or while MODE=0.
  - BUSY = (state==RUN), registered.
- Counting in RUN, on BASE_TICK:
  - If cnt == D-1: cnt <= 0, CLK_EN[i] asserted on the next cycle for exactly 1 cycle, CLK_DIV[i] toggles on that same cycle, and active divisor <= shadow.
  - Otherwise cnt <= cnt+1.
  - Period is D base ticks = D*PRESCALE CLK cycles.
  - D=0: the channel never pulses and the count holds at 0.
  - No overflow is possible, since cnt < D <= 2^CNT_WIDTH-1.
- Divisor writes:
  - DIV_WE[i] loads shadow <= DIV_DATA.
  - In IDLE the active divisor also loads immediately.
  - In RUN the active divisor changes only at a terminal tick, so no runt or stretched periods.
  - DIV_WE coinciding with a terminal tick: the active divisor takes DIV_DATA (write bypass).
  - Multiple DIV_WE bits may be set together; all addressed channels load.
- SYNC:
  - Clears pre_cnt, all channel counts and CLK_DIV.
  - Copies shadow to active on every channel.
  - Suppresses CLK_EN and BASE_TICK for that cycle.
  - Channel states are unchanged, so running channels restart phase-aligned.
- RST mid-operation returns everything to reset values on the next edge. A pending pulse is dropped.

Test Plan:
- PRESCALE=4, RESET_DIV=3; CH_EN[0]=1 and MODE[0]=0 held through reset release at cycle 0 -> BASE_TICK at cycles 3,7,11,...; CLK_EN[0] at cycles 12,24,36; CLK_DIV[0] rises at 12, falls at 24; BUSY[0]=1 from cycle 1.
- Ch0 running D=3; DIV_WE[0] with DIV_DATA=5 mid-period -> the current period stays 12 cycles; the following periods are 20 cycles; no extra or missing pulse. Repeat with DIV_WE on the terminal-tick cycle -> the next period is already 20.
- MODE[1]=1, D=2, START[1] pulsed -> exactly one CLK_EN[1], 8 cycles after the first subsequent BASE_TICK window; BUSY[1] falls with it. A second START while BUSY -> ignored.
- Channels 0..3 with D=1,2,3,4 running; pulse SYNC -> no CLK_EN that cycle; all channels' next pulses occur at PRESCALE*D cycles after SYNC; CLK_DIV all 0 after SYNC.
- GLOBAL_EN low for 10 cycles -> BASE_TICK and CLK_EN stop, counts hold; on re-enable the period resumes with the remaining ticks. D=0 written -> CLK_EN never asserts.
- RST asserted mid-period and CH_EN[0] dropped mid-period (separate runs) -> outputs 0 on the next cycle; after release, the first pulse takes a full period.
